// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction fetch queue:
// FSM state encoding, line-offset derivation and the queue entry layout.
package ifetch_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } ifq_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifq_entry_t;

    // Number of byte-offset bits inside one cache line.
    function automatic int line_offs(input int cl_size);
        return $clog2(cl_size / 8);
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer that accepts FETCH_W entries per push and releases one
// entry per pop. The head entry is read straight from storage, so data is
// visible the cycle after it is written. Flush empties the buffer at once.
module ifq_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int FETCH_W = 2,
    parameter int CW      = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  ifq_entry_t [FETCH_W-1:0] push_data,
    output ifq_entry_t               head,
    output logic [CW-1:0]            count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ifq_entry_t    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop_en;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int k);
        return PW'((int'(p) + k) % DEPTH);
    endfunction

    // A pop only happens when something is there and no flush overrides it.
    assign pop_en = pop && (count != '0) && !flush;
    assign head   = mem[rd_ptr];

    // Pointer and occupancy tracking; flush takes priority over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_add(wr_ptr, FETCH_W);
            if (pop_en)
                rd_ptr <= ptr_add(rd_ptr, 1);
            count <= count + (push ? CW'(FETCH_W) : CW'(0)) - (pop_en ? CW'(1) : CW'(0));
        end
    end

    // Entry storage: FETCH_W consecutive slots written in slot order.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            for (int i = 0; i < FETCH_W; i++)
                mem[ptr_add(wr_ptr, i)] <= push_data[i];
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage behind the split even/odd instruction cache. Takes the line
// pair returned each cycle, extracts FETCH_W sequential instructions starting
// at the fetch PC (possibly straddling into the next line), and queues them
// toward decode. Owns the fetch PC and discards the two cycles of in-flight
// responses after a redirect.
// Optional: define IFQ_STATS_EN to add the drop_cnt output, a saturating
// count of RUN cycles where both banks hit but the pair was rejected.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int          CL_SIZE  = 128,
    parameter int          FETCH_W  = 2,
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hit_e,
    input  logic               hit_o,
    input  logic [CL_SIZE-1:0] cl_e,
    input  logic [CL_SIZE-1:0] cl_o,
    input  logic [31:0]        addr_out_e,
    input  logic [31:0]        addr_out_o,
    input  logic               is_write_e,
    input  logic               is_write_o,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [31:0]        fetch_pc,
    output logic               deq_valid,
    input  logic               deq_ready,
    output logic [31:0]        deq_instr,
    output logic [31:0]        deq_pc,
    output logic               ifq_full
`ifdef IFQ_STATS_EN
    ,
    output logic [31:0]        drop_cnt
`endif
);

    localparam int OFFS = line_offs(CL_SIZE);
    localparam int WPL  = CL_SIZE / 32;
    localparam int WI   = $clog2(2 * WPL);
    localparam int LW   = 32 - OFFS;
    localparam int CW   = $clog2(DEPTH + 1);

    ifq_state_t               state;
    logic [1:0]               drain_cnt;
    logic [31:0]              pc_q;
    logic [CW-1:0]            count;
    ifq_entry_t               head;

    logic [CL_SIZE-1:0]       cur_line;
    logic [CL_SIZE-1:0]       nxt_line;
    logic [31:0]              cur_addr;
    logic [31:0]              nxt_addr;
    logic [LW-1:0]            pc_line;
    logic [LW-1:0]            pc_line_nxt;
    logic [31:0]              win_words [2*WPL];
    logic [WI-1:0]            word_base;
    ifq_entry_t [FETCH_W-1:0] slots;
    logic                     pair_ok;
    logic                     room_ok;
    logic                     accept;
    logic                     unused_addr_bits;

    // Offset bits of the returned addresses carry no information here.
    assign unused_addr_bits = ^{addr_out_e[OFFS-1:0], addr_out_o[OFFS-1:0]};

    // The bank holding the fetch PC is "current"; the other bank must hold
    // the sequentially following line.
    assign pc_line     = pc_q[31:OFFS];
    assign pc_line_nxt = pc_line + LW'(1);
    assign cur_line    = pc_q[OFFS] ? cl_o : cl_e;
    assign nxt_line    = pc_q[OFFS] ? cl_e : cl_o;
    assign cur_addr    = pc_q[OFFS] ? addr_out_o : addr_out_e;
    assign nxt_addr    = pc_q[OFFS] ? addr_out_e : addr_out_o;

    assign pair_ok = hit_e && hit_o && !is_write_e && !is_write_o
                     && (cur_addr[31:OFFS] == pc_line)
                     && (nxt_addr[31:OFFS] == pc_line_nxt);
    // Room is judged on the occupancy before any pop this cycle.
    assign room_ok = (count <= CW'(DEPTH - FETCH_W));
    assign accept  = (state == ST_RUN) && !redirect && pair_ok && room_ok;

    // Two-line window {next, current} split into 32-bit words.
    always_comb begin
        for (int w = 0; w < WPL; w++) begin
            win_words[w]       = cur_line[32*w +: 32];
            win_words[WPL + w] = nxt_line[32*w +: 32];
        end
    end

    assign word_base = WI'(pc_q[OFFS-1:2]);

    // Slot i is the word at fetch_pc + 4i; high slots spill into the next line.
    always_comb begin
        for (int i = 0; i < FETCH_W; i++) begin
            slots[i].pc    = pc_q + 32'(4 * i);
            slots[i].instr = win_words[word_base + WI'(i)];
        end
    end

    // Fetch control: fetch PC, RUN/DRAIN state and the post-redirect drain count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            drain_cnt <= 2'd0;
            pc_q      <= RESET_PC;
        end else if (redirect) begin
            state     <= ST_DRAIN;
            drain_cnt <= 2'd2;
            pc_q      <= redirect_pc & ~32'h3;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept)
                        pc_q <= pc_q + 32'(4 * FETCH_W);
                end
                ST_DRAIN: begin
                    if (drain_cnt <= 2'd1) begin
                        state     <= ST_RUN;
                        drain_cnt <= 2'd0;
                    end else begin
                        drain_cnt <= drain_cnt - 2'd1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    ifq_fifo #(
        .DEPTH   (DEPTH),
        .FETCH_W (FETCH_W),
        .CW      (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (accept),
        .pop       (deq_ready),
        .push_data (slots),
        .head      (head),
        .count     (count)
    );

    assign fetch_pc  = pc_q;
    assign deq_valid = (count != '0);
    // Storage is not reset, so the head is masked while the queue is empty.
    assign deq_instr = deq_valid ? head.instr : 32'h0;
    assign deq_pc    = deq_valid ? head.pc : 32'h0;
    assign ifq_full  = (count > CW'(DEPTH - FETCH_W));

`ifdef IFQ_STATS_EN
    // Saturating count of RUN cycles where both banks hit but nothing was taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt <= 32'h0;
        else if ((state == ST_RUN) && !redirect && hit_e && hit_o && !accept
                 && (drop_cnt != 32'hFFFF_FFFF))
            drop_cnt <= drop_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a driver issues line pairs, redirects
// and dequeue requests while a line-level reference model predicts accepted
// instructions into a queue; a monitor pops and compares on each dequeue.
module tb_ifetch_queue;

    localparam int          CL    = 128;
    localparam int          FW    = 2;
    localparam int          DEPTH = 8;
    localparam int          OFFS  = 4;
    localparam int          WPL   = CL / 32;
    localparam logic [31:0] RPC   = 32'h0000_1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          hit_e, hit_o, is_write_e, is_write_o, redirect, deq_ready;
    logic [CL-1:0] cl_e, cl_o;
    logic [31:0]   addr_out_e, addr_out_o, redirect_pc;
    logic [31:0]   fetch_pc, deq_instr, deq_pc;
    logic          deq_valid, ifq_full;

    ifetch_queue #(
        .CL_SIZE (CL),
        .FETCH_W (FW),
        .DEPTH   (DEPTH),
        .RESET_PC(RPC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .hit_e      (hit_e),
        .hit_o      (hit_o),
        .cl_e       (cl_e),
        .cl_o       (cl_o),
        .addr_out_e (addr_out_e),
        .addr_out_o (addr_out_o),
        .is_write_e (is_write_e),
        .is_write_o (is_write_o),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .fetch_pc   (fetch_pc),
        .deq_valid  (deq_valid),
        .deq_ready  (deq_ready),
        .deq_instr  (deq_instr),
        .deq_pc     (deq_pc),
        .ifq_full   (ifq_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb_q[$];
    int          cur_cnt, nxt_cnt, cur_drain, nxt_drain;
    logic [31:0] cur_pc, nxt_pc;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Addresses a cache would return for a hit on the line pair at pc.
    function automatic void match(input logic [31:0] pc, output logic [31:0] ae,
                                  output logic [31:0] ao);
        logic [31:0] ln;
        logic [31:0] c;
        logic [31:0] n;
        ln = pc >> OFFS;
        c  = ln << OFFS;
        n  = (ln + 32'd1) << OFFS;
        if (ln[0]) begin ao = c; ae = n; end
        else       begin ae = c; ao = n; end
    endfunction

    task automatic model_reset();
        sb_q.delete();
        cur_cnt = 0; nxt_cnt = 0; cur_drain = 0; nxt_drain = 0;
        cur_pc = RPC; nxt_pc = RPC;
    endtask

    task automatic set_idle();
        hit_e = 0; hit_o = 0; is_write_e = 0; is_write_o = 0;
        redirect = 0; redirect_pc = 0; deq_ready = 0;
        addr_out_e = 0; addr_out_o = 0;
    endtask

    // One cycle: drive inputs for the next edge and predict its outcome.
    task automatic step(input bit he, input bit ho, input bit we, input bit wo,
                        input bit rdy, input bit rdr, input logic [31:0] ae,
                        input logic [31:0] ao, input logic [31:0] rpc, input bit rnd_cl);
        logic [31:0]   line, a, ca, na;
        logic [CL-1:0] ld;
        bit            acc, pop;
        exp_t          e;
        @(posedge clk); #1;
        cur_cnt = nxt_cnt; cur_pc = nxt_pc; cur_drain = nxt_drain;
        hit_e = he; hit_o = ho; is_write_e = we; is_write_o = wo;
        deq_ready = rdy; redirect = rdr; redirect_pc = rpc;
        addr_out_e = ae; addr_out_o = ao;
        if (rnd_cl) begin
            cl_e = {$urandom(), $urandom(), $urandom(), $urandom()};
            cl_o = {$urandom(), $urandom(), $urandom(), $urandom()};
        end else begin
            cl_e = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
            cl_o = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        end
        if (rdr) begin
            sb_q.delete();
            nxt_cnt = 0; nxt_pc = rpc & 32'hFFFF_FFFC; nxt_drain = 2;
        end else begin
            line = cur_pc >> OFFS;
            ca = line[0] ? ao : ae;
            na = line[0] ? ae : ao;
            acc = (cur_drain == 0) && he && ho && !we && !wo
                  && ((ca >> OFFS) == line)
                  && ((na >> OFFS) == ((line + 32'd1) & 32'h0FFF_FFFF))
                  && ((DEPTH - cur_cnt) >= FW);
            pop = (cur_cnt > 0) && rdy;
            nxt_cnt = cur_cnt + (acc ? FW : 0) - (pop ? 1 : 0);
            nxt_drain = (cur_drain > 0) ? cur_drain - 1 : 0;
            nxt_pc = cur_pc;
            if (acc) begin
                for (int i = 0; i < FW; i++) begin
                    a = cur_pc + 32'(4 * i);
                    ld = a[OFFS] ? cl_o : cl_e;
                    e.pc = a;
                    e.instr = ld[32 * ((a >> 2) % WPL) +: 32];
                    sb_q.push_back(e);
                end
                nxt_pc = cur_pc + 32'(4 * FW);
            end
        end
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 0, 0, rdy, 0, 32'h0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic good(input bit rdy, input bit rnd_cl);
        logic [31:0] ae, ao;
        match(nxt_pc, ae, ao);
        step(1, 1, 0, 0, rdy, 0, ae, ao, 32'h0, rnd_cl);
    endtask

    task automatic redir(input logic [31:0] pc, input bit rdy);
        step(0, 0, 0, 0, rdy, 1, 32'h0, 32'h0, pc, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " fetch_pc"}, fetch_pc, RPC);
        chk({tag, " deq_valid"}, 32'(deq_valid), 32'h0);
        chk({tag, " deq_instr"}, deq_instr, 32'h0);
        chk({tag, " deq_pc"}, deq_pc, 32'h0);
        chk({tag, " ifq_full"}, 32'(ifq_full), 32'h0);
    endtask

    task automatic async_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        set_idle();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Monitor: checks visible state and every dequeue against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) continue;
            chk("deq_valid", 32'(deq_valid), 32'(cur_cnt != 0));
            chk("ifq_full", 32'(ifq_full), 32'((DEPTH - cur_cnt) < FW));
            chk("fetch_pc", fetch_pc, cur_pc);
            if (deq_valid && deq_ready && !redirect) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL deq_pop: dequeue of pc %h with nothing expected", deq_pc);
                end else begin
                    e = sb_q.pop_front();
                    chk("deq_pc", deq_pc, e.pc);
                    chk("deq_instr", deq_instr, e.instr);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Driver: directed scenarios, mid-stream reset, then random traffic.
    initial begin
        logic [31:0] ae, ao, rpc;
        bit          he, ho, we, wo, rdy;
        rst = 1'b1;
        set_idle();
        cl_e = '0; cl_o = '0;
        model_reset();
        #3;
        check_reset_outputs("reset");
        #4;
        rst = 1'b0;

        // Aligned fetch at 0x1000, then dequeue A0 and A1.
        good(0, 0);
        idle(1); idle(1); idle(1);

        // Straddle: 0x100C takes the last even word and the first odd word.
        redir(32'h0000_100C, 1); idle(1); idle(1);
        good(0, 0);
        idle(1); idle(1); idle(1);

        // Odd current line accepted, then a wrong even address rejected.
        redir(32'h0000_1010, 1); idle(1); idle(1);
        step(1, 1, 0, 0, 0, 0, 32'h0000_1020, 32'h0000_1010, 32'h0, 1'b0);
        step(1, 1, 0, 0, 0, 0, 32'h0000_1000, 32'h0000_1010, 32'h0, 1'b0);
        idle(1); idle(1); idle(1);

        // Backpressure: four accepts fill the queue, the fifth is dropped.
        redir(32'h0000_1000, 1); idle(0); idle(0);
        for (int i = 0; i < 5; i++) good(0, 1);
        for (int i = 0; i < 9; i++) idle(1);

        // Redirect with six queued entries; pop in the same cycle loses.
        for (int i = 0; i < 3; i++) good(0, 1);
        redir(32'h0000_2003, 1);
        good(0, 1); good(0, 1); good(0, 1);
        idle(1); idle(1); idle(1);

        // Asynchronous reset with a non-empty queue.
        for (int i = 0; i < 3; i++) good(0, 1);
        async_reset();
        idle(1);

        // Random traffic, including redirects near the top of the address space.
        for (int n = 0; n < 3000; n++) begin
            rdy = (n < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 3) begin
                rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 + 32'($urandom_range(0, 31))
                                                  : $urandom();
                redir(rpc, rdy);
            end else begin
                match(nxt_pc, ae, ao);
                case ($urandom_range(0, 11))
                    0: ae = ae + 32'h20;
                    1: ao = ao - 32'h20;
                    2: begin rpc = ae; ae = ao; ao = rpc; end
                    default: ;
                endcase
                he = ($urandom_range(0, 7) != 0);
                ho = ($urandom_range(0, 7) != 0);
                we = ($urandom_range(0, 19) == 0);
                wo = ($urandom_range(0, 19) == 0);
                step(he, ho, we, wo, rdy, 0, ae, ao, 32'h0, 1'b1);
            end
        end
        for (int i = 0; i < 10; i++) idle(1);
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_chk++;
            $display("FAIL leftover: %0d expected entries never dequeued", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
